uart_rx_sampler: RTL and testbench

- Serial byte receiver that sits directly upstream of the keyboard controller. It turns the raw asynchronous keyboard serial line into parallel bytes.
- Frame format is 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); idle line is 1.
- It oversamples by clock count and samples each bit at mid-period.
- It presents a byte plus a level-type ready flag. The flag stays high until the next frame begins, so the consumer can track both the ready and not-ready phases of each frame.

---
 rtl/uart_rx_sampler_if.sv | 19 +
 rtl/uart_rx_sampler.sv | 120 ++++++++++++
 tb/tb_uart_rx_sampler.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sampler_if.sv
// Serial-line side and byte-output side of the keyboard UART receiver.
// The receiver is the slave; whoever drives the line and consumes bytes is the master.
interface uart_rx_sampler_if;
  logic       IN_SERIAL_RX;
  logic [7:0] RX_DATA;
  logic       RX_READY;
  logic       RX_FRAME_ERR;
  logic       RX_BUSY;

  modport slave (
    input  IN_SERIAL_RX,
    output RX_DATA, RX_READY, RX_FRAME_ERR, RX_BUSY
  );

  modport master (
    output IN_SERIAL_RX,
    input  RX_DATA, RX_READY, RX_FRAME_ERR, RX_BUSY
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// 8N1 serial receiver: two-flop synchronizer, mid-bit sampling by clock count,
// level ready flag held from a good stop bit until the next start edge.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic               CLK,
  input  logic               RESET_N,
  uart_rx_sampler_if.slave   bus
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             ferr_q, ferr_d;
  logic             rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q    <= 2'b11;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], bus.IN_SERIAL_RX};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = ready_q;
    ferr_d    = ferr_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
          ready_d = 1'b0;
        end
      end
      // Half a bit in: a start bit still low here is real, otherwise a glitch.
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            ferr_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // A held-low line must return high before another start edge counts.
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.RX_DATA      = data_q;
  assign bus.RX_READY     = ready_q;
  assign bus.RX_FRAME_ERR = ferr_q;
  assign bus.RX_BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Randomized scoreboard bench for uart_rx_sampler at 16 clocks per bit.
module tb_uart_rx_sampler;
  localparam int C       = 16;
  localparam int EXP_LAT = 3 + C/2 + 9*C + 1;

  logic CLK = 1'b0;
  logic RESET_N;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  uart_rx_sampler_if u_if();

  uart_rx_sampler #(.CLKS_PER_BIT(C), .CNT_W(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(u_if.slave)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         t_fall;
  } ev_t;

  ev_t        q[$];
  logic [7:0] last_good = 8'h00;
  bit         m_ferr = 1'b0;
  int         pin_fall_cyc = 0;
  int         drop_lat = -1;
  int         last_hi = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    nchk++;
    if (act < lo || act > hi) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Monitor: every rising ready or frame-error flag consumes one expected event.
  initial begin
    logic prev_rdy = 1'b0, prev_err = 1'b0;
    int   hi_len = 0;
    ev_t  e;
    forever begin
      @(negedge CLK);
      if (RESET_N) begin
        if (u_if.RX_READY && !prev_rdy) begin
          chk("ready_event_pending", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("ready_event_kind", int'(e.is_err), 0);
            chk("ready_data", int'(u_if.RX_DATA), int'(e.data));
            chk("ready_ferr_clear", int'(u_if.RX_FRAME_ERR), 0);
            chk_rng("ready_latency", cyc - e.t_fall, EXP_LAT - 2, EXP_LAT + 2);
          end
        end
        if (u_if.RX_FRAME_ERR && !prev_err) begin
          chk("ferr_event_pending", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("ferr_event_kind", int'(e.is_err), 1);
            chk("ferr_data_kept", int'(u_if.RX_DATA), int'(e.data));
            chk("ferr_no_ready", int'(u_if.RX_READY), 0);
          end
        end
        if (!u_if.RX_READY && prev_rdy) begin
          drop_lat = cyc - pin_fall_cyc;
          last_hi  = hi_len;
        end
        hi_len = u_if.RX_READY ? hi_len + 1 : 0;
      end else begin
        hi_len = 0;
      end
      prev_rdy = u_if.RX_READY;
      prev_err = u_if.RX_FRAME_ERR;
    end
  end

  task automatic drive_bit(input logic v);
    u_if.IN_SERIAL_RX = v;
    repeat (C) @(negedge CLK);
  endtask

  task automatic idle(input int n);
    u_if.IN_SERIAL_RX = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Reference model: a good frame yields its byte; a bad stop raises the error
  // (only visible as an event if it was not already set) and keeps the old byte.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    pin_fall_cyc = cyc;
    if (stop_ok) begin
      q.push_back('{1'b0, b, cyc});
      last_good = b;
      m_ferr    = 1'b0;
    end else begin
      if (!m_ferr) q.push_back('{1'b1, last_good, -1});
      m_ferr = 1'b1;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok ? 1'b1 : 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, busy, gap;
    logic [7:0] b;
    bit ok;
    RESET_N = 1'b0;
    u_if.IN_SERIAL_RX = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_data",  int'(u_if.RX_DATA), 0);
    chk("rst_ready", int'(u_if.RX_READY), 0);
    chk("rst_ferr",  int'(u_if.RX_FRAME_ERR), 0);
    chk("rst_busy",  int'(u_if.RX_BUSY), 0);
    RESET_N = 1'b1;
    idle(10);

    send_frame(8'hA5, 1'b1);
    idle(10);
    chk("a5_data", int'(u_if.RX_DATA), 'hA5);

    // Ready must hold, with the old byte, across an idle gap.
    send_frame(8'h1C, 1'b1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      u_if.IN_SERIAL_RX = 1'b1;
      @(negedge CLK);
      if (!u_if.RX_READY || u_if.RX_DATA != 8'h1C) bad++;
    end
    chk("gap_hold_bad_cycles", bad, 0);
    send_frame(8'hF0, 1'b1);
    chk_rng("ready_drop_latency", drop_lat, 1, 4);
    idle(10);

    // Bad stop followed by a long break.
    send_frame(8'h3C, 1'b0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      u_if.IN_SERIAL_RX = 1'b0;
      @(negedge CLK);
      if (u_if.RX_READY) bad++;
    end
    chk("break_no_ready", bad, 0);
    chk("break_ferr", int'(u_if.RX_FRAME_ERR), 1);
    chk("break_data_kept", int'(u_if.RX_DATA), 'hF0);
    idle(10);

    // Short low glitch on an idle line.
    u_if.IN_SERIAL_RX = 1'b0;
    busy = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) u_if.IN_SERIAL_RX = 1'b1;
      @(negedge CLK);
      if (u_if.RX_BUSY) busy++;
    end
    chk_rng("glitch_busy_cycles", busy, 1, 12);
    chk("glitch_ready", int'(u_if.RX_READY), 0);
    chk("glitch_data",  int'(u_if.RX_DATA), 'hF0);
    chk("glitch_ferr",  int'(u_if.RX_FRAME_ERR), 1);

    send_frame(8'h55, 1'b1);
    idle(5);
    chk("good_after_break_ferr", int'(u_if.RX_FRAME_ERR), 0);

    // Back-to-back frames, no idle between.
    send_frame(8'h81, 1'b1);
    send_frame(8'h7E, 1'b1);
    chk_rng("b2b_ready_pulse", last_hi, 5, 64);
    idle(5);

    // Reset in the middle of data bit 4 of 0xFF.
    pin_fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (C/2) @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("midrst_data",  int'(u_if.RX_DATA), 0);
    chk("midrst_ready", int'(u_if.RX_READY), 0);
    chk("midrst_ferr",  int'(u_if.RX_FRAME_ERR), 0);
    chk("midrst_busy",  int'(u_if.RX_BUSY), 0);
    last_good = 8'h00;
    m_ferr    = 1'b0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    idle(5);
    send_frame(8'h12, 1'b1);
    idle(5);
    chk("post_reset_data", int'(u_if.RX_DATA), 'h12);

    for (int n = 0; n < 12; n++) begin
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 4) != 0);
      send_frame(b, ok);
      gap = ok ? $urandom_range(0, 20) : $urandom_range(4, 20);
      idle(gap);
    end

    idle(3*C);
    chk("queue_drained", q.size(), 0);
    chk("final_data", int'(u_if.RX_DATA), int'(last_good));
    chk("final_ferr", int'(u_if.RX_FRAME_ERR), int'(m_ferr));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
